// File: rtl/ins_pkg.sv
// Shared definitions for the instruction fetch/decode sequencer.
//   - fetch_state_e : sequencer state encoding
//   - MODE/LEN/OPC  : bit ranges of the fields in the first instruction word
//   - LEN_*         : length field encodings (number of ROM words per instruction)
//   - HALT_MODE/OPC : mode/opcode pair that stops the sequencer
package ins_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_FETCH_EXT,
      ST_ISSUE,
      ST_EXEC,
      ST_HALT
   } fetch_state_e;

   localparam int MODE_HI = 15;
   localparam int MODE_LO = 14;
   localparam int LEN_HI  = 13;
   localparam int LEN_LO  = 12;
   localparam int OPC_HI  = 11;
   localparam int OPC_LO  = 8;

   localparam logic [1:0] LEN_1W   = 2'b00;
   localparam logic [1:0] LEN_1W_B = 2'b01;
   localparam logic [1:0] LEN_2W   = 2'b10;
   localparam logic [1:0] LEN_3W   = 2'b11;

   localparam logic [1:0] HALT_MODE = 2'b11;
   localparam logic [3:0] HALT_OPC  = 4'hF;

   function automatic logic needs_ext(input logic [15:0] w);
      return (w[LEN_HI:LEN_LO] == LEN_2W) || (w[LEN_HI:LEN_LO] == LEN_3W);
   endfunction

   function automatic logic is_halt(input logic [15:0] w);
      return (w[MODE_HI:MODE_LO] == HALT_MODE) && (w[OPC_HI:OPC_LO] == HALT_OPC);
   endfunction

endpackage

// File: rtl/ins_fetch_ctrl_rom_rd_port.sv
// ROM read port shared by the first-word and extension-word fetch states.
// The requester holds req_i and addr_i until ack_o; the address is driven
// straight from the caller's register so it cannot move mid-read, and
// rom_valid is only honoured while a request is outstanding.
// Ports:
//   req_i, addr_i   : read request and word address from the sequencer
//   rom_rd, rom_addr: ROM-side request and address
//   rom_valid, rom_data : ROM-side response
//   ack_o, data_o   : qualified response back to the sequencer
module rom_rd_port #(
   parameter int PC_W = 16
) (
   input  logic            req_i,
   input  logic [PC_W-1:0] addr_i,
   output logic            rom_rd,
   output logic [PC_W-1:0] rom_addr,
   input  logic            rom_valid,
   input  logic [15:0]     rom_data,
   output logic            ack_o,
   output logic [15:0]     data_o
);

   assign rom_rd   = req_i;
   assign rom_addr = addr_i;
   assign ack_o    = req_i & rom_valid;
   assign data_o   = rom_data;

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Fetch/decode sequencer in front of the instruction-field decoder. Keeps the
// program counter, reads 1-3 ROM words per instruction, strobes the decoder,
// issues to execute and waits for completion. One instruction in flight.
// Optional feature macro: FETCH_JUMP_EN adds jump_en/jump_addr, letting
// execute redirect the pc when it reports completion.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : leave IDLE and fetch from pc
//   rom_rd/rom_addr     : ROM request, address held until rom_valid
//   rom_data/rom_valid  : ROM response
//   ins_load            : one-cycle decoder load strobe, ins_word valid
//   ins_word/ext0/ext1  : instruction word and extension words
//   exec_start/exec_done: execute handshake
//   pc, busy, halted    : status
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_FETCH     | reading first instruction word at pc
// ST_DECODE    | ins_load strobe, choose extension fetch or issue
// ST_FETCH_EXT | reading extension word(s), ext_idx selects ext0/ext1
// ST_ISSUE     | exec_start strobe
// ST_EXEC      | waiting for exec_done
// ST_HALT      | halt instruction retired, only reset leaves
module ins_fetch_ctrl
   import ins_pkg::*;
#(
   parameter int              PC_W   = 16,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            rom_rd,
   output logic [PC_W-1:0] rom_addr,
   input  logic [15:0]     rom_data,
   input  logic            rom_valid,
   output logic            ins_load,
   output logic [15:0]     ins_word,
   output logic [15:0]     ext0,
   output logic [15:0]     ext1,
   output logic            exec_start,
   input  logic            exec_done,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
`ifdef FETCH_JUMP_EN
   ,
   input  logic            jump_en,
   input  logic [PC_W-1:0] jump_addr
`endif
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ins_q, ins_d;
   logic [15:0]     ext0_q, ext0_d;
   logic [15:0]     ext1_q, ext1_d;
   logic            ext_idx_q, ext_idx_d;
   logic            rd_req;
   logic            rd_ack;
   logic [15:0]     rd_data;

   rom_rd_port #(.PC_W(PC_W)) u_rom_rd_port (
      .req_i    (rd_req),
      .addr_i   (pc_q),
      .rom_rd   (rom_rd),
      .rom_addr (rom_addr),
      .rom_valid(rom_valid),
      .rom_data (rom_data),
      .ack_o    (rd_ack),
      .data_o   (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ins_d      = ins_q;
      ext0_d     = ext0_q;
      ext1_d     = ext1_q;
      ext_idx_d  = ext_idx_q;
      rd_req     = 1'b0;
      ins_load   = 1'b0;
      exec_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            rd_req = 1'b1;
            if (rd_ack) begin
               ins_d   = rd_data;
               pc_d    = pc_q + PC_ONE;
               ext0_d  = '0;
               ext1_d  = '0;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ins_load  = 1'b1;
            ext_idx_d = 1'b0;
            state_d   = needs_ext(ins_q) ? ST_FETCH_EXT : ST_ISSUE;
         end
         ST_FETCH_EXT: begin
            rd_req = 1'b1;
            if (rd_ack) begin
               pc_d = pc_q + PC_ONE;
               if (!ext_idx_q) ext0_d = rd_data;
               else            ext1_d = rd_data;
               // a 2-word instruction is complete after ext0, a 3-word one after ext1
               if (ext_idx_q || (ins_q[LEN_HI:LEN_LO] == LEN_2W)) state_d = ST_ISSUE;
               else                                               ext_idx_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            exec_start = 1'b1;
            state_d    = ST_EXEC;
         end
         ST_EXEC: begin
            if (exec_done) begin
               if (is_halt(ins_q)) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_FETCH;
`ifdef FETCH_JUMP_EN
                  if (jump_en) pc_d = jump_addr;
`endif
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RST_PC;
         ins_q     <= '0;
         ext0_q    <= '0;
         ext1_q    <= '0;
         ext_idx_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ins_q     <= ins_d;
         ext0_q    <= ext0_d;
         ext1_q    <= ext1_d;
         ext_idx_q <= ext_idx_d;
      end
   end

   assign ins_word = ins_q;
   assign ext0     = ext0_q;
   assign ext1     = ext1_q;
   assign pc       = pc_q;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
module tb_ins_fetch_ctrl;

   logic        clk;
   logic        rst, start, rom_rd, rom_valid, ins_load, exec_start, exec_done, busy, halted;
   logic [15:0] rom_addr, rom_data, ins_word, ext0, ext1, pc;

   logic        rst2, start2, rom_rd2, rom_valid2, ins_load2, exec_start2, exec_done2, busy2, halted2;
   logic [15:0] rom_addr2, rom_data2, ins_word2, ext0_2, ext1_2, pc2;
`ifdef FETCH_JUMP_EN
   logic        jump_en, jump_en2;
   logic [15:0] jump_addr, jump_addr2;
`endif

   logic [15:0] mem  [16];
   logic [15:0] mem2 [16];
   int          rom_dly;
   int          rom_cnt;
   int          checks;
   int          errors;

   ins_fetch_ctrl #(.PC_W(16), .RST_PC(16'h0000)) u_dut (
      .clk(clk), .rst(rst), .start(start), .rom_rd(rom_rd), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_valid(rom_valid), .ins_load(ins_load), .ins_word(ins_word),
      .ext0(ext0), .ext1(ext1), .exec_start(exec_start), .exec_done(exec_done), .pc(pc),
      .busy(busy), .halted(halted)
`ifdef FETCH_JUMP_EN
      , .jump_en(jump_en), .jump_addr(jump_addr)
`endif
   );

   ins_fetch_ctrl #(.PC_W(16), .RST_PC(16'hFFFF)) u_dut_wrap (
      .clk(clk), .rst(rst2), .start(start2), .rom_rd(rom_rd2), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .rom_valid(rom_valid2), .ins_load(ins_load2), .ins_word(ins_word2),
      .ext0(ext0_2), .ext1(ext1_2), .exec_start(exec_start2), .exec_done(exec_done2), .pc(pc2),
      .busy(busy2), .halted(halted2)
`ifdef FETCH_JUMP_EN
      , .jump_en(jump_en2), .jump_addr(jump_addr2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: answers rom_dly negedges after the request is seen, one word per answer
   always @(negedge clk) begin
      if (rom_rd) begin
         if (rom_cnt >= rom_dly) begin
            rom_valid = 1'b1;
            rom_data  = mem[rom_addr[3:0]];
            rom_cnt   = 0;
         end else begin
            rom_valid = 1'b0;
            rom_cnt   = rom_cnt + 1;
         end
      end else begin
         rom_valid = 1'b0;
         rom_cnt   = 0;
      end
   end

   always @(negedge clk) begin
      rom_valid2 = rom_rd2;
      rom_data2  = mem2[rom_addr2[3:0]];
   end

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rom_rd, ins_load, exec_start, busy, halted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 00000", {rom_rd, ins_load, exec_start, busy, halted});
      end
      checks++;
      if ({ins_word, ext0, ext1, pc} !== 64'h0) begin
         errors++;
         $display("FAIL reset_regs: got %h want 0", {ins_word, ext0, ext1, pc});
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: busy got %b want 0", busy);
      end
   endtask

   task automatic test_one_word();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({rom_rd, rom_addr, busy} !== {1'b1, 16'h0000, 1'b1}) begin
         errors++;
         $display("FAIL one_fetch: rd/addr/busy got %b/%h/%b want 1/0000/1", rom_rd, rom_addr, busy);
      end
      @(negedge clk);
      checks++;
      if ({ins_load, ins_word, pc, exec_start, rom_rd} !== {1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL one_decode: load/word/pc/es/rd got %b/%h/%h/%b/%b want 1/0100/0001/0/0",
                  ins_load, ins_word, pc, exec_start, rom_rd);
      end
      @(negedge clk);
      checks++;
      if ({exec_start, ins_load} !== 2'b10) begin
         errors++;
         $display("FAIL one_issue: es/load got %b%b want 10", exec_start, ins_load);
      end
      @(negedge clk);
      checks++;
      if ({exec_start, busy, rom_rd} !== 3'b010) begin
         errors++;
         $display("FAIL one_exec: es/busy/rd got %b%b%b want 010", exec_start, busy, rom_rd);
      end
   endtask

   task automatic test_two_word();
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      checks++;
      if ({rom_rd, rom_addr} !== {1'b1, 16'h0001}) begin
         errors++;
         $display("FAIL two_refetch: rd/addr got %b/%h want 1/0001", rom_rd, rom_addr);
      end
      @(negedge clk);
      checks++;
      if ({ins_load, ins_word, ext0, pc} !== {1'b1, 16'h2200, 16'h0000, 16'h0002}) begin
         errors++;
         $display("FAIL two_decode: load/word/ext0/pc got %b/%h/%h/%h want 1/2200/0000/0002",
                  ins_load, ins_word, ext0, pc);
      end
      exec_done = 1'b1;
      @(negedge clk);
      checks++;
      if ({rom_rd, rom_addr, ins_load, exec_start} !== {1'b1, 16'h0002, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL two_ext: rd/addr/load/es got %b/%h/%b/%b want 1/0002/0/0",
                  rom_rd, rom_addr, ins_load, exec_start);
      end
      @(negedge clk);
      checks++;
      if ({exec_start, ext0, ext1, pc, rom_rd} !== {1'b1, 16'hABCD, 16'h0000, 16'h0003, 1'b0}) begin
         errors++;
         $display("FAIL two_issue: es/ext0/ext1/pc/rd got %b/%h/%h/%h/%b want 1/abcd/0000/0003/0",
                  exec_start, ext0, ext1, pc, rom_rd);
      end
      @(negedge clk);
      exec_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({exec_start, busy, rom_rd} !== 3'b010) begin
            errors++;
            $display("FAIL two_exec_wait%0d: es/busy/rd got %b%b%b want 010", i, exec_start, busy, rom_rd);
         end
      end
   endtask

   task automatic test_three_word_slow();
      rom_dly = 3;
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({rom_rd, rom_addr, ins_load} !== {1'b1, 16'h0003, 1'b0}) begin
            errors++;
            $display("FAIL slow_fetch%0d: rd/addr/load got %b/%h/%b want 1/0003/0", i, rom_rd, rom_addr, ins_load);
         end
      end
      @(negedge clk);
      checks++;
      if ({ins_load, ins_word, pc} !== {1'b1, 16'h3300, 16'h0004}) begin
         errors++;
         $display("FAIL slow_decode: load/word/pc got %b/%h/%h want 1/3300/0004", ins_load, ins_word, pc);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({rom_rd, rom_addr, exec_start} !== {1'b1, 16'h0004, 1'b0}) begin
            errors++;
            $display("FAIL slow_ext0_%0d: rd/addr/es got %b/%h/%b want 1/0004/0", i, rom_rd, rom_addr, exec_start);
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({rom_rd, rom_addr, ext0, ext1, exec_start} !== {1'b1, 16'h0005, 16'h1111, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL slow_ext1_%0d: rd/addr/ext0/ext1/es got %b/%h/%h/%h/%b want 1/0005/1111/0000/0",
                     i, rom_rd, rom_addr, ext0, ext1, exec_start);
         end
      end
      @(negedge clk);
      checks++;
      if ({exec_start, ext0, ext1, pc, rom_rd} !== {1'b1, 16'h1111, 16'h2222, 16'h0006, 1'b0}) begin
         errors++;
         $display("FAIL slow_issue: es/ext0/ext1/pc/rd got %b/%h/%h/%h/%b want 1/1111/2222/0006/0",
                  exec_start, ext0, ext1, pc, rom_rd);
      end
      @(negedge clk);
      rom_dly = 0;
   endtask

   task automatic test_halt();
      logic [15:0] exp_w;
      for (int i = 0; i < 3; i++) begin
         exp_w = mem[6 + i];
         exec_done = 1'b1;
         @(negedge clk);
         exec_done = 1'b0;
         checks++;
         if ({rom_rd, rom_addr, halted} !== {1'b1, 16'(6 + i), 1'b0}) begin
            errors++;
            $display("FAIL halt_fetch%0d: rd/addr/halted got %b/%h/%b want 1/%h/0", i, rom_rd, rom_addr, halted, 16'(6 + i));
         end
         @(negedge clk);
         checks++;
         if ({ins_load, ins_word} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL halt_decode%0d: load/word got %b/%h want 1/%h", i, ins_load, ins_word, exp_w);
         end
         repeat (2) @(negedge clk);
      end
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      checks++;
      if ({halted, busy, rom_rd, pc} !== {1'b1, 1'b0, 1'b0, 16'h0009}) begin
         errors++;
         $display("FAIL halt_enter: halted/busy/rd/pc got %b/%b/%b/%h want 1/0/0/0009", halted, busy, rom_rd, pc);
      end
      for (int i = 0; i < 20; i++) begin
         start = i[0];
         exec_done = i[1];
         @(negedge clk);
         checks++;
         if ({halted, busy, rom_rd, exec_start, ins_load} !== 5'b10000) begin
            errors++;
            $display("FAIL halt_hold%0d: halted/busy/rd/es/load got %b%b%b%b%b want 10000",
                     i, halted, busy, rom_rd, exec_start, ins_load);
         end
      end
      start = 1'b0;
      exec_done = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({halted, busy, rom_rd, pc, ins_word} !== {3'b000, 16'h0000, 16'h0000}) begin
         errors++;
         $display("FAIL halt_reset: halted/busy/rd/pc/word got %b%b%b/%h/%h want 000/0000/0000",
                  halted, busy, rom_rd, pc, ins_word);
      end
   endtask

   task automatic test_reset_mid_fetch();
      mem[0] = 16'h3300;
      rom_dly = 3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({ins_load, ins_word} !== {1'b1, 16'h3300}) begin
         errors++;
         $display("FAIL midrst_decode: load/word got %b/%h want 1/3300", ins_load, ins_word);
      end
      @(negedge clk);
      checks++;
      if ({rom_rd, rom_addr} !== {1'b1, 16'h0001}) begin
         errors++;
         $display("FAIL midrst_ext: rd/addr got %b/%h want 1/0001", rom_rd, rom_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({rom_rd, busy, ins_word, ext0, pc} !== {2'b00, 16'h0000, 16'h0000, 16'h0000}) begin
         errors++;
         $display("FAIL midrst_after: rd/busy/word/ext0/pc got %b%b/%h/%h/%h want 00/0000/0000/0000",
                  rom_rd, busy, ins_word, ext0, pc);
      end
      @(negedge clk);
      checks++;
      if ({rom_rd, busy} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_idle: rd/busy got %b%b want 00", rom_rd, busy);
      end
      rom_dly = 0;
   endtask

   task automatic test_wrap();
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      checks++;
      if ({pc2, busy2, halted2} !== {16'hFFFF, 2'b00}) begin
         errors++;
         $display("FAIL wrap_reset: pc/busy/halted got %h/%b%b want ffff/00", pc2, busy2, halted2);
      end
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      checks++;
      if ({rom_rd2, rom_addr2} !== {1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL wrap_fetch: rd/addr got %b/%h want 1/ffff", rom_rd2, rom_addr2);
      end
      @(negedge clk);
      checks++;
      if ({ins_load2, ins_word2, pc2} !== {1'b1, 16'h2200, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_decode: load/word/pc got %b/%h/%h want 1/2200/0000", ins_load2, ins_word2, pc2);
      end
      @(negedge clk);
      checks++;
      if ({rom_rd2, rom_addr2} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_ext: rd/addr got %b/%h want 1/0000", rom_rd2, rom_addr2);
      end
      @(negedge clk);
      checks++;
      if ({exec_start2, ext0_2, ext1_2, pc2} !== {1'b1, 16'h5A5A, 16'h0000, 16'h0001}) begin
         errors++;
         $display("FAIL wrap_issue: es/ext0/ext1/pc got %b/%h/%h/%h want 1/5a5a/0000/0001",
                  exec_start2, ext0_2, ext1_2, pc2);
      end
      @(negedge clk);
      exec_done2 = 1'b1;
`ifdef FETCH_JUMP_EN
      jump_en2 = 1'b1;
      jump_addr2 = 16'h0040;
      @(negedge clk);
      exec_done2 = 1'b0;
      jump_en2 = 1'b0;
      checks++;
      if ({rom_rd2, rom_addr2, pc2} !== {1'b1, 16'h0040, 16'h0040}) begin
         errors++;
         $display("FAIL wrap_jump: rd/addr/pc got %b/%h/%h want 1/0040/0040", rom_rd2, rom_addr2, pc2);
      end
`else
      @(negedge clk);
      exec_done2 = 1'b0;
      checks++;
      if ({rom_rd2, rom_addr2, pc2} !== {1'b1, 16'h0001, 16'h0001}) begin
         errors++;
         $display("FAIL wrap_next: rd/addr/pc got %b/%h/%h want 1/0001/0001", rom_rd2, rom_addr2, pc2);
      end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rom_dly = 0;
      rom_cnt = 0;
      rom_valid = 1'b0;
      rom_data = 16'h0;
      rom_valid2 = 1'b0;
      rom_data2 = 16'h0;
      rst = 1'b1;
      start = 1'b0;
      exec_done = 1'b0;
      rst2 = 1'b1;
      start2 = 1'b0;
      exec_done2 = 1'b0;
`ifdef FETCH_JUMP_EN
      jump_en = 1'b0;
      jump_addr = 16'h0;
      jump_en2 = 1'b0;
      jump_addr2 = 16'h0;
`endif
      for (int i = 0; i < 16; i++) begin
         mem[i] = 16'h0;
         mem2[i] = 16'h0;
      end
      mem[0] = 16'h0100;
      mem[1] = 16'h2200;
      mem[2] = 16'hABCD;
      mem[3] = 16'h3300;
      mem[4] = 16'h1111;
      mem[5] = 16'h2222;
      mem[6] = 16'hCE00;
      mem[7] = 16'h0F00;
      mem[8] = 16'hCF00;
      mem2[15] = 16'h2200;
      mem2[0] = 16'h5A5A;

      test_reset();
      test_one_word();
      test_two_word();
      test_three_word_slow();
      test_halt();
      test_reset_mid_fetch();
      test_wrap();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
